// File: rtl/reverse_rotation_engine_f_pkg.sv
// Shared Enigma constants: inverse rotor wirings (Enigma I rotors I/II/III,
// ring setting A) and mod-26 helpers used by the forward and return paths.
package reverse_rotation_engine_f_pkg;

  localparam int unsigned LETTERS = 26;

  typedef logic [4:0] letter_t;

  // Inverse wirings, index 0 = A, value 0 = A.
  // INV_I   = "UWYGADFPVZBECKMTHXSLRINQOJ"
  localparam letter_t INV_I [LETTERS] = '{
    5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21, 5'd25,
    5'd1,  5'd4,  5'd2,  5'd10, 5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11,
    5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9
  };

  // INV_II  = "AJPCZWRLFBDKOTYUQGENHXMIVS"
  localparam letter_t INV_II [LETTERS] = '{
    5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,
    5'd3,  5'd10, 5'd14, 5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13,
    5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18
  };

  // INV_III = "TAGBPCSDQEUFVNZHYIXJWLRKOM"
  localparam letter_t INV_III [LETTERS] = '{
    5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16, 5'd4,
    5'd20, 5'd5,  5'd21, 5'd13, 5'd25, 5'd7,  5'd24, 5'd8,  5'd23, 5'd9,
    5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12
  };

  // (a + b) mod 26 for in-range operands: 6-bit sum, one conditional subtract.
  function automatic letter_t add_mod26(input letter_t a, input letter_t b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(LETTERS)) s = s - 6'(LETTERS);
    return s[4:0];
  endfunction

  // (a - b) mod 26 for in-range operands: borrow handled by adding 26 first.
  function automatic letter_t sub_mod26(input letter_t a, input letter_t b);
    logic [5:0] s;
    if (a < b) s = {1'b0, a} + 6'(LETTERS) - {1'b0, b};
    else       s = {1'b0, a} - {1'b0, b};
    return s[4:0];
  endfunction

  // Inverse-wiring lookup by rotor number; indices past Z read as 0 so an
  // out-of-range contact never walks off the table.
  function automatic letter_t inv_wire(input int unsigned rotor_id, input letter_t idx);
    letter_t v;
    v = '0;
    if (idx < 5'(LETTERS)) begin
      case (rotor_id)
        1:       v = INV_I[idx];
        2:       v = INV_II[idx];
        default: v = INV_III[idx];
      endcase
    end
    return v;
  endfunction

endpackage

// File: rtl/reverse_rotation_engine_f_rotor_inv_stage.sv
// One rotor on the return path: shift into the rotor frame by its position,
// pass through the inverse wiring, shift back out. Purely combinational.
module rotor_inv_stage
  import reverse_rotation_engine_f_pkg::*;
#(
  parameter int unsigned ROTOR_ID = 1
) (
  input  logic [4:0] x,
  input  logic [4:0] pos,
  output logic [4:0] y
);

  letter_t entry;
  letter_t wired;

  // Entry contact, wiring lookup, exit contact.
  always_comb begin
    entry = add_mod26(x, pos);
    wired = inv_wire(ROTOR_ID, entry);
    y     = sub_mod26(wired, pos);
  end

endmodule

// File: rtl/reverse_rotation_engine_f.sv
// Enigma return path: reflector output through rotor 3, 2, 1 inverse wirings.
// Combinational chain, all three stage results registered together (1 cycle).
module reverse_rotation_engine_f
  import reverse_rotation_engine_f_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] data_in,
  input  logic [4:0] r1_pos_F,
  input  logic [4:0] r2_pos_F,
  input  logic [4:0] r3_pos_F,
  output logic [4:0] r3_out,
  output logic [4:0] r2_out,
  output logic [4:0] r1_out
);

  localparam letter_t MAX_LETTER = 5'(LETTERS - 1);

  letter_t r3_y, r2_y, r1_y;
  letter_t r3_d, r2_d, r1_d;
  letter_t r3_q, r2_q, r1_q;
  logic    in_range;

  rotor_inv_stage #(.ROTOR_ID(3)) u_r3 (.x(data_in), .pos(r3_pos_F), .y(r3_y));
  rotor_inv_stage #(.ROTOR_ID(2)) u_r2 (.x(r3_y),    .pos(r2_pos_F), .y(r2_y));
  rotor_inv_stage #(.ROTOR_ID(1)) u_r1 (.x(r2_y),    .pos(r1_pos_F), .y(r1_y));

  // Any letter or position beyond Z blanks all three results.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    r3_d = '0;
    r2_d = '0;
    r1_d = '0;
    in_range = (data_in  <= MAX_LETTER) && (r1_pos_F <= MAX_LETTER) &&
               (r2_pos_F <= MAX_LETTER) && (r3_pos_F <= MAX_LETTER);
    if (in_range) begin
      r3_d = r3_y;
      r2_d = r2_y;
      r1_d = r1_y;
    end
  end

  // Capture all stage results on the same edge; reset clears them asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r3_q <= '0;
      r2_q <= '0;
      r1_q <= '0;
    end else begin
      r3_q <= r3_d;
      r2_q <= r2_d;
      r1_q <= r1_d;
    end
  end

  assign r3_out = r3_q;
  assign r2_out = r2_q;
  assign r1_out = r1_q;

endmodule

// File: tb/tb_reverse_rotation_engine_f.sv
// Self-checking bench for reverse_rotation_engine_f: directed vectors, a sweep
// for bijectivity and latency, out-of-range blanking, async reset, and random
// traffic against a letter-string reference model.
module tb_reverse_rotation_engine_f;

  logic       clk;
  logic       rst_n;
  logic [4:0] data_in;
  logic [4:0] r1_pos_F, r2_pos_F, r3_pos_F;
  logic [4:0] r3_out, r2_out, r1_out;

  int n_checks = 0;
  int n_errors = 0;

  reverse_rotation_engine_f dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .r1_pos_F (r1_pos_F),
    .r2_pos_F (r2_pos_F),
    .r3_pos_F (r3_pos_F),
    .r3_out   (r3_out),
    .r2_out   (r2_out),
    .r1_out   (r1_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam string W_I   = "UWYGADFPVZBECKMTHXSLRINQOJ";
  localparam string W_II  = "AJPCZWRLFBDKOTYUQGENHXMIVS";
  localparam string W_III = "TAGBPCSDQEUFVNZHYIXJWLRKOM";

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: one rotor in letter terms, straight modular arithmetic.
  function automatic int ref_stage(input int x, input int p, input string w);
    int y;
    y = int'(w.getc((x + p) % 26)) - 65;
    return (y - p + 26) % 26;
  endfunction

  function automatic void ref_chain(input int d, input int p1, input int p2, input int p3,
                                    output int e3, output int e2, output int e1);
    if (d > 25 || p1 > 25 || p2 > 25 || p3 > 25) begin
      e3 = 0; e2 = 0; e1 = 0;
    end else begin
      e3 = ref_stage(d,  p3, W_III);
      e2 = ref_stage(e3, p2, W_II);
      e1 = ref_stage(e2, p1, W_I);
    end
  endfunction

  // Drive at negedge, capture at posedge, sample 1 time unit later.
  task automatic apply(input int d, input int p1, input int p2, input int p3);
    @(negedge clk);
    data_in  = 5'(d);
    r1_pos_F = 5'(p1);
    r2_pos_F = 5'(p2);
    r3_pos_F = 5'(p3);
  endtask

  task automatic step_check(input string tag, input int d, input int p1, input int p2, input int p3);
    int e3, e2, e1;
    ref_chain(d, p1, p2, p3, e3, e2, e1);
    apply(d, p1, p2, p3);
    @(posedge clk);
    #1;
    check({tag, ".r3"}, int'(r3_out), e3);
    check({tag, ".r2"}, int'(r2_out), e2);
    check({tag, ".r1"}, int'(r1_out), e1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".r3"}, int'(r3_out), 0);
    check({tag, ".r2"}, int'(r2_out), 0);
    check({tag, ".r1"}, int'(r1_out), 0);
  endtask

  initial begin : stim
    int e3, e2, e1, p3, p2, p1;
    int prev3, prev2, prev1;
    logic [25:0] seen;
    int d, q1, q2, q3;

    rst_n = 1'b0;
    data_in = '0; r1_pos_F = '0; r2_pos_F = '0; r3_pos_F = '0;
    #2;
    check_zero("reset_initial");
    @(posedge clk);
    #1;
    check_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with explicit expected letters.
    apply(0, 0, 0, 0);
    @(posedge clk); #1;
    check("pos000_d0.r3", int'(r3_out), 19);
    check("pos000_d0.r2", int'(r2_out), 13);
    check("pos000_d0.r1", int'(r1_out), 10);

    apply(0, 25, 3, 2);
    @(posedge clk); #1;
    check("pos25_3_2_d0.r3", int'(r3_out), 4);
    check("pos25_3_2_d0.r2", int'(r2_out), 8);
    check("pos25_3_2_d0.r1", int'(r1_out), 16);

    apply(25, 25, 3, 2);
    @(posedge clk); #1;
    check("pos25_3_2_d25.r3", int'(r3_out), 24);
    check("pos25_3_2_d25.r2", int'(r2_out), 6);
    check("pos25_3_2_d25.r1", int'(r1_out), 4);

    // Async reset mid-stream: outputs are non-zero here (24/6/4).
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    @(posedge clk); #1;
    check_zero("reset_held_edge");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_zero("reset_released_preedge");
    step_check("after_reset", 7, 4, 11, 19);

    // Sweep 0..25 at fixed positions: latency and bijectivity.
    p1 = 9; p2 = 17; p3 = 23;
    seen = '0;
    ref_chain(7, 4, 11, 19, prev3, prev2, prev1);
    for (int i = 0; i < 26; i++) begin
      apply(i, p1, p2, p3);
      #1;
      check("sweep_lag.r1", int'(r1_out), prev1);
      check("sweep_lag.r3", int'(r3_out), prev3);
      ref_chain(i, p1, p2, p3, e3, e2, e1);
      @(posedge clk); #1;
      check("sweep.r3", int'(r3_out), e3);
      check("sweep.r2", int'(r2_out), e2);
      check("sweep.r1", int'(r1_out), e1);
      seen[r1_out] = 1'b1;
      prev3 = e3; prev2 = e2; prev1 = e1;
    end
    check("sweep_bijective", $countones(seen), 26);

    // Out-of-range blanking and recovery.
    step_check("valid_pre_oor", 3, 1, 2, 3);
    step_check("data_26", 26, 1, 2, 3);
    step_check("recover1", 12, 5, 6, 7);
    step_check("r2pos_30", 12, 5, 30, 7);
    step_check("recover2", 12, 5, 6, 7);
    step_check("data_31", 31, 0, 0, 0);
    step_check("r1pos_26", 4, 26, 0, 0);
    step_check("r3pos_31", 4, 0, 0, 31);

    // Random traffic with occasional out-of-range values.
    for (int i = 0; i < 300; i++) begin
      d  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(26, 31)) : int'($urandom_range(0, 25));
      q1 = ($urandom_range(0, 31) == 0) ? int'($urandom_range(26, 31)) : int'($urandom_range(0, 25));
      q2 = ($urandom_range(0, 31) == 0) ? int'($urandom_range(26, 31)) : int'($urandom_range(0, 25));
      q3 = ($urandom_range(0, 31) == 0) ? int'($urandom_range(26, 31)) : int'($urandom_range(0, 25));
      step_check("random", d, q1, q2, q3);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
